riscv_soft_alu_issue: RTL and testbench

Registered decode-and-issue stage that produces ALU operation codes and operands. It turns one RV32I instruction word plus its register-file read data into a 4-bit ALU operation, operand pair and branch-compare flags, and presents them to the ALU under a valid/ready handshake. It sits between register read and the ALU, with exactly one cycle of latency.

---
 rtl/riscv_soft_alu_issue_pkg.sv | 78 +++++++
 rtl/riscv_soft_alu_issue_decode.sv | 99 +++++++++
 rtl/riscv_soft_alu_issue.sv | 110 +++++++++++
 tb/tb_riscv_soft_alu_issue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_soft_alu_issue_pkg.sv
// Shared constants for the RV32I decode-and-issue stage: ALU op codes, opcodes,
// funct fields and the issue payload struct.
package riscv_soft_alu_issue_pkg;

    localparam int unsigned XPR_LEN  = 32;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SEQ  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SNE  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SGE  = 4'd13;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd14;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SGEU = 4'd15;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [XPR_LEN-1:0]  operand_1;
        logic [XPR_LEN-1:0]  operand_2;
        logic                is_branch;
        logic                cmp_invert;
        logic                illegal;
        logic [XPR_LEN-1:0]  pc;
    } issue_t;

    // Register/immediate arithmetic map; alt selects SUB or SRA.
    function automatic logic [ALU_OP_W-1:0] arith_op(input logic [2:0] funct3, input logic alt);
        logic [ALU_OP_W-1:0] op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            F3_SLL:     op = ALU_OP_SLL;
            F3_SLT:     op = ALU_OP_SLT;
            F3_SLTU:    op = ALU_OP_SLTU;
            F3_XOR:     op = ALU_OP_XOR;
            F3_SR:      op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            F3_OR:      op = ALU_OP_OR;
            default:    op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_soft_alu_issue_decode.sv
// Combinational RV32I decode: instruction word, pc and register data to ALU op,
// operands and branch-compare flags.
module riscv_soft_alu_issue_decode
    import riscv_soft_alu_issue_pkg::*;
(
    input  logic [31:0]        i_inst,
    input  logic [XPR_LEN-1:0] i_pc,
    input  logic [XPR_LEN-1:0] i_rs1_data,
    input  logic [XPR_LEN-1:0] i_rs2_data,
    output issue_t             o_dec_c
);

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [XPR_LEN-1:0] w_imm_i;
    logic [XPR_LEN-1:0] w_imm_s;
    logic [XPR_LEN-1:0] w_imm_u;
    logic [XPR_LEN-1:0] w_shamt;
    logic               w_illegal;
    issue_t             w_dec;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];
    assign w_imm_i  = {{(XPR_LEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{(XPR_LEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_u  = {i_inst[31:12], 12'b0};
    assign w_shamt  = XPR_LEN'(i_inst[24:20]);

    always_comb begin
        w_illegal = 1'b0;
        w_dec     = '0;
        w_dec.op  = ALU_OP_ADD;
        w_dec.pc  = i_pc;
        case (w_opcode)
            OPC_OP: begin
                w_illegal       = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                w_dec.op        = arith_op(w_funct3, w_funct7[5]);
                w_dec.operand_1 = i_rs1_data;
                w_dec.operand_2 = i_rs2_data;
            end
            OPC_OP_IMM: begin
                w_illegal       = (w_funct3 == F3_SLL) && (w_funct7 != F7_BASE);
                w_dec.op        = arith_op(w_funct3, (w_funct3 == F3_SR) && w_funct7[5]);
                w_dec.operand_1 = i_rs1_data;
                w_dec.operand_2 = ((w_funct3 == F3_SLL) || (w_funct3 == F3_SR)) ? w_shamt : w_imm_i;
            end
            OPC_BRANCH: begin
                // GE forms reuse the LT compare and invert the result.
                w_dec.is_branch = 1'b1;
                w_dec.operand_1 = i_rs1_data;
                w_dec.operand_2 = i_rs2_data;
                case (w_funct3)
                    F3_BEQ:  w_dec.op = ALU_OP_SEQ;
                    F3_BNE:  w_dec.op = ALU_OP_SNE;
                    F3_BLT:  w_dec.op = ALU_OP_SLT;
                    F3_BGE: begin
                        w_dec.op         = ALU_OP_SLT;
                        w_dec.cmp_invert = 1'b1;
                    end
                    F3_BLTU: w_dec.op = ALU_OP_SLTU;
                    F3_BGEU: begin
                        w_dec.op         = ALU_OP_SLTU;
                        w_dec.cmp_invert = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_dec.operand_1 = i_rs1_data;
                w_dec.operand_2 = w_imm_i;
            end
            OPC_STORE: begin
                w_dec.operand_1 = i_rs1_data;
                w_dec.operand_2 = w_imm_s;
            end
            OPC_LUI: w_dec.operand_2 = w_imm_u;
            OPC_AUIPC: begin
                w_dec.operand_1 = i_pc;
                w_dec.operand_2 = w_imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                w_dec.operand_1 = i_pc;
                w_dec.operand_2 = XPR_LEN'(4);
            end
            default: w_illegal = 1'b1;
        endcase

        o_dec_c = w_dec;
        if (w_illegal) begin
            o_dec_c         = '0;
            o_dec_c.op      = ALU_OP_ADD;
            o_dec_c.illegal = 1'b1;
            o_dec_c.pc      = i_pc;
        end
    end

endmodule

// File: rtl/riscv_soft_alu_issue.sv
// Registered decode-and-issue stage with valid/ready on both sides.
// RISCV_SOFT_ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module riscv_soft_alu_issue
    import riscv_soft_alu_issue_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XPR_LEN-1:0]  in_pc,
    input  logic [XPR_LEN-1:0]  in_rs1_data,
    input  logic [XPR_LEN-1:0]  in_rs2_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] out_op,
    output logic [XPR_LEN-1:0]  out_operand_1,
    output logic [XPR_LEN-1:0]  out_operand_2,
    output logic                out_is_branch,
    output logic                out_cmp_invert,
    output logic                out_illegal,
    output logic [XPR_LEN-1:0]  out_pc
);

    issue_t w_dec;
    issue_t r_out;
    logic   r_out_valid;
    logic   w_accept;
    logic   w_out_fire;

    riscv_soft_alu_issue_decode u_decode (
        .i_inst     (in_inst),
        .i_pc       (in_pc),
        .i_rs1_data (in_rs1_data),
        .i_rs2_data (in_rs2_data),
        .o_dec_c    (w_dec)
    );

    assign w_out_fire = r_out_valid & out_ready;

`ifdef RISCV_SOFT_ALU_ISSUE_SKID_EN
    issue_t r_skid;
    logic   r_skid_valid;
    logic   r_in_ready;

    assign in_ready = r_in_ready;
    assign w_accept = in_valid & r_in_ready & ~flush;

    // Output register backed by one skid entry; in_ready drops once the skid fills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            if (w_out_fire) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (!r_out_valid || w_out_fire) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    // Single output register; a new entry replaces a departing one with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_dec;
            end
        end
    end
`endif

    assign out_valid      = r_out_valid;
    assign out_op         = r_out.op;
    assign out_operand_1  = r_out.operand_1;
    assign out_operand_2  = r_out.operand_2;
    assign out_is_branch  = r_out.is_branch;
    assign out_cmp_invert = r_out.cmp_invert;
    assign out_illegal    = r_out.illegal;
    assign out_pc         = r_out.pc;

    wire unused_fire = w_out_fire;

endmodule

// File: tb/tb_riscv_soft_alu_issue.sv
// Self-checking bench for riscv_soft_alu_issue: queue-based issue model checked
// every cycle, plus directed literal expectations.
module tb_riscv_soft_alu_issue;

    localparam logic [3:0] A_ADD = 4'd0,  A_SLL = 4'd1,  A_XOR = 4'd4,  A_SRL = 4'd5;
    localparam logic [3:0] A_OR  = 4'd6,  A_AND = 4'd7,  A_SEQ = 4'd8,  A_SNE = 4'd9;
    localparam logic [3:0] A_SUB = 4'd10, A_SRA = 4'd11, A_SLT = 4'd12, A_SLTU = 4'd14;
`ifdef RISCV_SOFT_ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        inv;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_operand_1;
    logic [31:0] out_operand_2;
    logic        out_is_branch;
    logic        out_cmp_invert;
    logic        out_illegal;
    logic [31:0] out_pc;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t p_ent;
    logic p_push  = 1'b0;
    logic p_pop   = 1'b0;
    logic p_flush = 1'b0;

    riscv_soft_alu_issue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_op         (out_op),
        .out_operand_1  (out_operand_1),
        .out_operand_2  (out_operand_2),
        .out_is_branch  (out_is_branch),
        .out_cmp_invert (out_cmp_invert),
        .out_illegal    (out_illegal),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // What an RV32I instruction must issue as, from the ISA's view.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t               e;
        logic [3:0]         tab [8];
        logic signed [31:0] sinst;
        logic [31:0]        iimm, simm, uimm, shamt;
        int unsigned        opc, f3, f7;
        logic               ill;
        tab   = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        sinst = inst;
        iimm  = sinst >>> 20;
        simm  = (iimm & ~32'h1F) | ((inst >> 7) & 32'h1F);
        uimm  = inst & 32'hFFFF_F000;
        shamt = (inst >> 20) & 32'h1F;
        opc   = inst & 32'h7F;
        f3    = (inst >> 12) & 32'h7;
        f7    = inst >> 25;
        ill   = 1'b0;
        e     = '{op: A_ADD, a: 0, b: 0, br: 0, inv: 0, ill: 0, pc: pc};
        case (opc)
            32'h33: begin
                ill = !(f7 == 0 || f7 == 32);
                e.op = (f7 == 32 && f3 == 0) ? A_SUB : (f7 == 32 && f3 == 5) ? A_SRA : tab[f3];
                e.a = rs1; e.b = rs2;
            end
            32'h13: begin
                ill = (f3 == 1 && f7 != 0);
                e.op = (f3 == 5 && (f7 & 32) != 0) ? A_SRA : tab[f3];
                e.a = rs1; e.b = (f3 == 1 || f3 == 5) ? shamt : iimm;
            end
            32'h63: begin
                e.br = 1'b1; e.a = rs1; e.b = rs2;
                case (f3)
                    0: e.op = A_SEQ;
                    1: e.op = A_SNE;
                    4: e.op = A_SLT;
                    5: begin e.op = A_SLT; e.inv = 1'b1; end
                    6: e.op = A_SLTU;
                    7: begin e.op = A_SLTU; e.inv = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            32'h03: begin e.a = rs1; e.b = iimm; end
            32'h23: begin e.a = rs1; e.b = simm; end
            32'h37: e.b = uimm;
            32'h17: begin e.a = pc; e.b = uimm; end
            32'h6F, 32'h67: begin e.a = pc; e.b = 32'd4; end
            default: ill = 1'b1;
        endcase
        if (ill) e = '{op: A_ADD, a: 0, b: 0, br: 0, inv: 0, ill: 1'b1, pc: pc};
        return e;
    endfunction

    // Per-cycle comparison against the model, then record this cycle's handshake.
    task automatic model_compare();
        logic exp_ready;
        if (!reset_n) begin
            q.delete();
            p_push = 1'b0; p_pop = 1'b0; p_flush = 1'b0;
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_op", 32'(out_op), 32'd0);
            check("rst_op1", out_operand_1, 32'd0);
            check("rst_op2", out_operand_2, 32'd0);
            check("rst_pc", out_pc, 32'd0);
            check("rst_flags", 32'({out_is_branch, out_cmp_invert, out_illegal}), 32'd0);
            return;
        end
`ifdef RISCV_SOFT_ALU_ISSUE_SKID_EN
        exp_ready = (q.size() < 2);
`else
        exp_ready = (q.size() == 0) || out_ready;
`endif
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("m_op", 32'(out_op), 32'(q[0].op));
            check("m_op1", out_operand_1, q[0].a);
            check("m_op2", out_operand_2, q[0].b);
            check("m_flags", 32'({out_is_branch, out_cmp_invert, out_illegal}),
                  32'({q[0].br, q[0].inv, q[0].ill}));
            check("m_pc", out_pc, q[0].pc);
        end
        p_flush = flush;
        p_pop   = (q.size() != 0) && out_ready;
        p_push  = in_valid && exp_ready && !flush;
        if (p_push) p_ent = model(in_inst, in_pc, in_rs1_data, in_rs2_data);
    endtask

    task automatic model_update();
        if (!reset_n || p_flush) begin
            q.delete();
        end else begin
            if (p_pop) void'(q.pop_front());
            if (p_push) q.push_back(p_ent);
        end
        p_push = 1'b0; p_pop = 1'b0; p_flush = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    logic [31:0] vtab [25];
    logic [31:0] bp_inst [4];

    initial begin
        int idx, budget;
        logic acc;
        vtab = '{32'h00B50463, 32'h00B51463, 32'h00B54463, 32'h00B56463, 32'h00B52463,
                 32'h00B56533, 32'h00B57533, 32'h00B54533, 32'h00B52533, 32'h00B53533,
                 32'h00B51533, 32'h00B55533, 32'h40B55533, 32'h02B50533, 32'h00351513,
                 32'h40351513, 32'h00355513, 32'h80054513, 32'hFFF52513, 32'hFFC52503,
                 32'hFEB52E23, 32'h00001517, 32'h0000006F, 32'h000500E7, 32'h0000000F};
        bp_inst = '{32'h00150513, 32'h00250513, 32'h00350513, 32'h00450513};

        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00B50533; in_pc = 32'h40;
        in_rs1_data = 32'd5; in_rs2_data = 32'd6;
        repeat (3) tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_op", 32'(out_op), 32'd0);
        reset_n = 1'b1;
        idle(1);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_idle_valid", 32'(out_valid), 32'd0);

        drive(32'h40B50533, 32'h100, 32'd10, 32'd3);
        check("sub_op", 32'(out_op), 32'd10);
        check("sub_op1", out_operand_1, 32'd10);
        check("sub_op2", out_operand_2, 32'd3);
        check("sub_pc", out_pc, 32'h100);
        drive(32'h00B50533, 32'h104, 32'd10, 32'd3);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_op", 32'(out_op), 32'd0);
        drive(32'h00B55463, 32'h108, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("bge_op", 32'(out_op), 32'd12);
        check("bge_flags", 32'({out_is_branch, out_cmp_invert}), 32'b11);
        drive(32'h00B57463, 32'h10C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("bgeu_op", 32'(out_op), 32'd14);
        check("bgeu_inv", 32'(out_cmp_invert), 32'd1);
        drive(32'h40355513, 32'h110, 32'h8000_0000, 32'd0);
        check("srai_op", 32'(out_op), 32'd11);
        check("srai_op2", out_operand_2, 32'd3);
        drive(32'hFFF50513, 32'h114, 32'd7, 32'd0);
        check("addi_op2", out_operand_2, 32'hFFFF_FFFF);
        drive(32'h12345537, 32'h118, 32'd9, 32'd9);
        check("lui_op1", out_operand_1, 32'd0);
        check("lui_op2", out_operand_2, 32'h1234_5000);
        drive(32'hFFFFFFFF, 32'h11C, 32'd9, 32'd9);
        check("illegal_flag", 32'(out_illegal), 32'd1);
        check("illegal_op", 32'(out_op), 32'd0);
        check("illegal_ops", out_operand_1 | out_operand_2, 32'd0);
        drive(32'hFEB52E23, 32'h120, 32'd64, 32'd1);
        check("sw_op2", out_operand_2, 32'hFFFF_FFFC);
        drive(32'h00001517, 32'h124, 32'd0, 32'd0);
        check("auipc_ops", out_operand_1 + out_operand_2, 32'h0000_1124);

        for (int i = 0; i < 25; i++)
            drive(vtab[i], 32'h200 + 32'(4 * i), 32'h8000_0010 + 32'(i), 32'(7 * i));
        idle(3);

        // Backpressure: stall the ALU side for three cycles while streaming.
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_inst = bp_inst[idx]; in_pc = 32'h300 + 32'(4 * idx);
            in_rs1_data = 32'd100; in_rs2_data = 32'd0;
            #1 acc = in_ready;
            tick();
            if (acc) idx++;
            check("bp_hold_op2", out_operand_2, 32'd1);
        end
        check("bp_accepted", 32'(idx), 32'(DEPTH));
        out_ready = 1'b1;
        budget = 0;
        while (idx < 4 && budget < 20) begin
            in_valid = 1'b1; in_inst = bp_inst[idx]; in_pc = 32'h300 + 32'(4 * idx);
            #1 acc = in_ready;
            tick();
            if (acc) idx++;
            budget++;
        end
        if (idx < 4) check("bp_drain_timeout", 32'(idx), 32'd4);
        idle(4);

        // Flush with a held entry, a buffered one and a valid input beat.
        out_ready = 1'b0;
        drive(32'h00B56533, 32'h400, 32'd1, 32'd2);
        drive(32'h00B57533, 32'h404, 32'd3, 32'd4);
        flush = 1'b1; out_ready = 1'b1;
        drive(32'h00B54533, 32'h408, 32'd5, 32'd6);
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        idle(1);
        check("flush_valid_2", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stalled transfer.
        out_ready = 1'b0;
        drive(32'h40B50533, 32'h500, 32'd20, 32'd1);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_op", 32'(out_op), 32'd0);
        check("async_op1", out_operand_1, 32'd0);
        tick();
        reset_n = 1'b1; out_ready = 1'b1;
        idle(1);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        drive(32'h00B50533, 32'h600, 32'd2, 32'd2);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
